// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word load, one bit per clk on sdo, optional idle gap.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every frame and expose parity_bit.
module piso_tx #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pdi,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             busy,
  output logic             done
`ifdef PISO_TX_PARITY_EN
  ,
  output logic             parity_bit
`endif
);

`ifdef PISO_TX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [7:0]       gap_cnt;
  logic             last_bit;
  logic             accept;

  // The bit about to go out always sits at the leading end of the shift register.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  always_comb begin
    last_bit   = (state == SHIFT) && (bit_cnt == LAST_CNT);
    load_ready = (state == IDLE) || (last_bit && (GAP_CYCLES == 0));
    accept     = load_valid && load_ready;
    cnt_next   = bit_cnt + 1'b1;
    shreg_next = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      sdo       <= 1'b0;
      sdo_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (accept) begin
      // Covers both a load from IDLE and a back-to-back load in the last-bit cycle.
      state     <= SHIFT;
      shreg     <= pdi;
      bit_cnt   <= '0;
      sdo       <= lead_bit(pdi);
      sdo_valid <= 1'b1;
      busy      <= 1'b1;
      done      <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      parity_bit <= ^pdi;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (last_bit) begin
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            done      <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
            if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= '0;
              busy    <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            bit_cnt <= cnt_next;
            shreg   <= shreg_next;
            done    <= (cnt_next == LAST_CNT);
`ifdef PISO_TX_PARITY_EN
            sdo <= (cnt_next == LAST_CNT) ? parity_bit : lead_bit(shreg_next);
`else
            sdo <= lead_bit(shreg_next);
`endif
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          sdo       <= 1'b0;
          sdo_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: two instances (MSB-first/no gap and LSB-first/3-cycle gap) share stimulus.
// Accepted words are expanded into expected bit queues; a negedge monitor pops one entry per valid bit.
module tb_piso_tx;
  localparam int WIDTH = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_valid;
  logic [WIDTH-1:0] pdi;
  logic [1:0]       load_ready;
  logic [1:0]       sdo;
  logic [1:0]       sdo_valid;
  logic [1:0]       busy;
  logic [1:0]       done;
`ifdef PISO_TX_PARITY_EN
  logic [1:0]       parity_bit;
`endif

  exp_t q0[$];
  exp_t q1[$];
  int   bits_left[2];
  int   gap_left[2];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(WIDTH), .MSB_FIRST(1), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .pdi(pdi), .load_valid(load_valid),
    .load_ready(load_ready[0]), .sdo(sdo[0]), .sdo_valid(sdo_valid[0]),
    .busy(busy[0]), .done(done[0])
`ifdef PISO_TX_PARITY_EN
    , .parity_bit(parity_bit[0])
`endif
  );

  piso_tx #(.WIDTH(WIDTH), .MSB_FIRST(0), .GAP_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .pdi(pdi), .load_valid(load_valid),
    .load_ready(load_ready[1]), .sdo(sdo[1]), .sdo_valid(sdo_valid[1]),
    .busy(busy[1]), .done(done[1])
`ifdef PISO_TX_PARITY_EN
    , .parity_bit(parity_bit[1])
`endif
  );

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic bit msb_of(input int d);
    return (d == 0);
  endfunction

  // A word can be taken when nothing is in flight, or on the final bit when no gap is owed.
  function automatic bit model_ready(input int d);
    return ((bits_left[d] == 0) && (gap_left[d] == 0)) ||
           ((gap_of(d) == 0) && (bits_left[d] == 1));
  endfunction

  task automatic push_frame(input int d, input logic [WIDTH-1:0] w);
    for (int i = 0; i < FRAME; i++) begin
      exp_t e;
      if (i < WIDTH) e.b = msb_of(d) ? w[WIDTH-1-i] : w[i];
      else           e.b = ^w;
      e.last = (i == FRAME - 1);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic compareBit(input string name, input int d, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("[TB] FAIL %s dut%0d: got %b expected %b at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input int d);
    exp_t e;
    bit   have;
    compareBit("sdo_valid", d, sdo_valid[d], bits_left[d] > 0);
    compareBit("busy", d, busy[d], (bits_left[d] > 0) || (gap_left[d] > 0));
    compareBit("load_ready", d, load_ready[d], model_ready(d));
    if (sdo_valid[d] === 1'b1) begin
      have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
      compareBit("queue_nonempty", d, have, 1'b1);
      if (have) begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        compareBit("sdo", d, sdo[d], e.b);
        compareBit("done", d, done[d], e.last);
      end
    end else begin
      compareBit("sdo_idle", d, sdo[d], 1'b0);
      compareBit("done_idle", d, done[d], 1'b0);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic lv, input logic [WIDTH-1:0] d);
    @(posedge clk);
    #1;
    reset      = rst;
    load_valid = lv;
    pdi        = d;
  endtask

  // Reference model: frame bookkeeping at each rising edge from the driven inputs only.
  initial begin : model
    bit rdy;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (reset) begin
          bits_left[d] = 0;
          gap_left[d]  = 0;
          if (d == 0) q0.delete();
          else        q1.delete();
        end else begin
          rdy = model_ready(d);
          if (bits_left[d] > 0) begin
            bits_left[d]--;
            if ((bits_left[d] == 0) && (gap_of(d) > 0)) gap_left[d] = gap_of(d);
          end else if (gap_left[d] > 0) begin
            gap_left[d]--;
          end
          if (load_valid && rdy) begin
            bits_left[d] = FRAME;
            push_frame(d, pdi);
          end
        end
      end
      if (reset) mon_en = 1'b1;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checkOutput(0);
        checkOutput(1);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic             rst;
    logic             lv;
    logic [WIDTH-1:0] w;
    bit               drained;
    reset      = 1'b1;
    load_valid = 1'b0;
    pdi        = '0;
    bits_left  = '{0, 0};
    gap_left   = '{0, 0};

    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(0, 0, 8'h00);
    repeat (3) applyStimulus(0, 0, 8'h00);

    // A5 then 3C offered exactly in the last-bit cycle of the first frame.
    applyStimulus(0, 1, 8'hA5);
    repeat (7) applyStimulus(0, 0, 8'hA5);
    applyStimulus(0, 1, 8'h3C);
    repeat (12) applyStimulus(0, 0, 8'h3C);

    // load_valid held high; pdi changes after acceptance.
    repeat (4) applyStimulus(0, 1, 8'hFF);
    repeat (20) applyStimulus(0, 1, 8'h00);
    repeat (15) applyStimulus(0, 0, 8'h00);

    // Reset during bit 4 with a load pending, then a clean reload.
    applyStimulus(0, 1, 8'hC3);
    repeat (3) applyStimulus(0, 0, 8'hC3);
    applyStimulus(1, 1, 8'h55);
    applyStimulus(0, 1, 8'h81);
    repeat (12) applyStimulus(0, 0, 8'h81);

    applyStimulus(0, 1, 8'h07);
    repeat (12) applyStimulus(0, 0, 8'h07);
    applyStimulus(0, 1, 8'h03);
    repeat (12) applyStimulus(0, 0, 8'h03);

    repeat (400) begin
      rst = ($urandom_range(0, 63) == 0);
      lv  = ($urandom_range(0, 2) == 0);
      w   = 8'($urandom);
      applyStimulus(rst, lv, w);
    end
    repeat (20) applyStimulus(0, 0, 8'h00);

    @(posedge clk);
    #1;
    drained = (q0.size() == 0);
    compareBit("drain", 0, drained, 1'b1);
    drained = (q1.size() == 0);
    compareBit("drain", 1, drained, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
